hex_word_serializer: RTL and testbench

HEX_WORD_SERIALIZER -- requirements
Module: hex_word_serializer

---
 rtl/hex_word_serializer.sv | 203 ++++++++++++++++++++
 tb/tb_hex_word_serializer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : hex_word_serializer
//  Purpose  : Prints one WIDTH-bit word as an ASCII hexadecimal string on a
//             byte-wide valid/ready stream. The string is an optional "0x"
//             prefix, then WIDTH/4 digits (most-significant nibble first,
//             leading zeros kept), then an optional CR LF. out_last marks the
//             final character of each word.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     : input word width, multiple of 4, 4..64
//    LOWERCASE : 1 = digits a-f, 0 = digits A-F
//    PREFIX    : 1 = emit "0x" before the digits
//    NEWLINE   : 1 = emit CR LF after the digits
//  Ports
//    clk        in   1      sole clock, rising edge
//    rst_n      in   1      asynchronous active-low reset
//    in_valid   in   1      in_data valid
//    in_ready   out  1      block can accept a word (idle only)
//    in_data    in   WIDTH  word to print
//    out_valid  out  1      out_char valid
//    out_ready  in   1      sink accepts out_char
//    out_char   out  8      ASCII character (8'h00 when out_valid = 0)
//    out_last   out  1      out_char is the final character of the word
//    busy       out  1      a word is in progress
// ============================================================================
module hex_word_serializer #(
  parameter int WIDTH     = 32,
  parameter bit LOWERCASE = 1'b0,
  parameter bit PREFIX    = 1'b1,
  parameter bit NEWLINE   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  // A single-digit word still needs a 1-bit counter.
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST_DIGIT = CNT_W'(NIBBLES - 1);

  localparam logic [7:0] C_CHAR_ZERO = 8'h30;
  localparam logic [7:0] C_CHAR_X    = 8'h78;
  localparam logic [7:0] C_CHAR_CR   = 8'h0D;
  localparam logic [7:0] C_CHAR_LF   = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PFX0  = 3'd1,
    ST_PFX1  = 3'd2,
    ST_DIGIT = 3'd3,
    ST_CR    = 3'd4,
    ST_LF    = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_in_ready;
  logic             w_out_valid;
  logic [7:0]       w_out_char;
  logic             w_out_last;

  logic [3:0]       w_nibble;
  logic [7:0]       w_alpha_base;
  logic [7:0]       w_digit_char;

  // --------------------------------------------------------------------------
  // Nibble-to-ASCII conversion. The digit on screen is always the top nibble
  // of the shift register; the register moves left by one nibble per digit.
  // --------------------------------------------------------------------------
  generate
    if (LOWERCASE) begin : g_lower
      assign w_alpha_base = 8'h61;
    end else begin : g_upper
      assign w_alpha_base = 8'h41;
    end
  endgenerate

  assign w_nibble = r_shift[WIDTH-1 -: 4];

  always_comb begin
    w_digit_char = C_CHAR_ZERO + {4'h0, w_nibble};
    if (w_nibble > 4'd9) begin
      w_digit_char = w_alpha_base + {4'h0, w_nibble} - 8'd10;
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode. Outputs depend only on registered state, so
  // they hold steady for as long as the sink stalls; state and digit position
  // advance only on an accepted character.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_char  = 8'h00;
    w_out_last  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_shift_nxt = in_data;
          w_cnt_nxt   = C_LAST_DIGIT;
          w_state_nxt = PREFIX ? ST_PFX0 : ST_DIGIT;
        end
      end

      ST_PFX0: begin
        w_out_valid = 1'b1;
        w_out_char  = C_CHAR_ZERO;
        if (out_ready) begin
          w_state_nxt = ST_PFX1;
        end
      end

      ST_PFX1: begin
        w_out_valid = 1'b1;
        w_out_char  = C_CHAR_X;
        if (out_ready) begin
          w_state_nxt = ST_DIGIT;
        end
      end

      ST_DIGIT: begin
        w_out_valid = 1'b1;
        w_out_char  = w_digit_char;
        w_out_last  = !NEWLINE && (r_cnt == '0);
        if (out_ready) begin
          w_shift_nxt = r_shift << 4;
          if (r_cnt == '0) begin
            w_state_nxt = NEWLINE ? ST_CR : ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end

      ST_CR: begin
        w_out_valid = 1'b1;
        w_out_char  = C_CHAR_CR;
        if (out_ready) begin
          w_state_nxt = ST_LF;
        end
      end

      ST_LF: begin
        w_out_valid = 1'b1;
        w_out_char  = C_CHAR_LF;
        w_out_last  = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // in_ready is masked by rst_n so it reads 0 while reset is held, even though
  // the state register already sits in IDLE.
  assign in_ready  = w_in_ready & rst_n;
  assign out_valid = w_out_valid;
  assign out_char  = w_out_char;
  assign out_last  = w_out_last;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hex_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_word_serializer
//  Purpose  : Self-checking bench for hex_word_serializer. Three instances
//             cover the default 32-bit configuration, a 16-bit lowercase
//             digits-only configuration and a 4-bit prefix-only configuration.
//             Expected strings come from a reference model that formats the
//             word with plain arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_word_serializer;

  typedef logic [7:0] ch_t;

  logic clk;
  logic rst_n;

  // Instance A: WIDTH=32, uppercase, prefix, newline
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [31:0] a_in_data;
  logic [7:0]  a_out_char;
  // Instance B: WIDTH=16, lowercase, no prefix, no newline
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [15:0] b_in_data;
  logic [7:0]  b_out_char;
  // Instance C: WIDTH=4, uppercase, prefix, no newline
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_busy;
  logic [3:0]  c_in_data;
  logic [7:0]  c_out_char;

  hex_word_serializer #(.WIDTH(32), .LOWERCASE(1'b0), .PREFIX(1'b1), .NEWLINE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_char(a_out_char),
    .out_last(a_out_last), .busy(a_busy)
  );

  hex_word_serializer #(.WIDTH(16), .LOWERCASE(1'b1), .PREFIX(1'b0), .NEWLINE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_char(b_out_char),
    .out_last(b_out_last), .busy(b_busy)
  );

  hex_word_serializer #(.WIDTH(4), .LOWERCASE(1'b0), .PREFIX(1'b1), .NEWLINE(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_char(c_out_char),
    .out_last(c_out_last), .busy(c_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int a_mode   = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: random

  ch_t chars[3][$];
  bit  lasts[3][$];
  int  cycs[3][$];

  logic a_stalled = 1'b0;
  ch_t  a_hold_char;
  logic a_hold_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Character collector plus stall-stability watch on instance A.
  always @(negedge clk) begin
    if (rst_n && a_stalled) begin
      check("stall_valid", a_out_valid, 1'b1);
      check("stall_char",  a_out_char,  a_hold_char);
      check("stall_last",  a_out_last,  a_hold_last);
    end
    a_stalled   = rst_n && a_out_valid && !a_out_ready;
    a_hold_char = a_out_char;
    a_hold_last = a_out_last;
    if (rst_n && a_out_valid && a_out_ready) begin
      chars[0].push_back(a_out_char); lasts[0].push_back(a_out_last); cycs[0].push_back(cyc);
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      chars[1].push_back(b_out_char); lasts[1].push_back(b_out_last); cycs[1].push_back(cyc);
    end
    if (rst_n && c_out_valid && c_out_ready) begin
      chars[2].push_back(c_out_char); lasts[2].push_back(c_out_last); cycs[2].push_back(cyc);
    end
  end

  // Sink backpressure driver for instance A.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (a_mode)
        1:       begin a_out_ready = (phase == 0); phase = (phase + 1) % 3; end
        2:       a_out_ready = 1'($urandom_range(0, 1));
        default: a_out_ready = 1'b1;
      endcase
    end
  end

  // Reference: "0x"? + hex digits MSB first + CR LF?
  function automatic void model(int width, bit lower, bit pfx, bit nl,
                                logic [63:0] w, output ch_t q[$]);
    int n;
    q.delete();
    if (pfx) begin q.push_back(8'h30); q.push_back(8'h78); end
    for (int i = width / 4 - 1; i >= 0; i--) begin
      n = int'((w >> (4 * i)) & 64'hF);
      if (n < 10) q.push_back(ch_t'(48 + n));
      else        q.push_back(ch_t'((lower ? 97 : 65) + n - 10));
    end
    if (nl) begin q.push_back(8'h0D); q.push_back(8'h0A); end
  endfunction

  function automatic void from_bits(logic [95:0] v, int n, output ch_t q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(v[8 * (n - 1 - i) +: 8]);
  endfunction

  task automatic clear(int which);
    chars[which].delete(); lasts[which].delete(); cycs[which].delete();
  endtask

  task automatic send(int which, logic [63:0] w);
    @(posedge clk); #1;
    case (which)
      0:       begin a_in_data = w[31:0]; a_in_valid = 1'b1; end
      1:       begin b_in_data = w[15:0]; b_in_valid = 1'b1; end
      default: begin c_in_data = w[3:0];  c_in_valid = 1'b1; end
    endcase
    @(posedge clk); #1;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
  endtask

  task automatic wait_chars(int which, int n, int budget);
    int k;
    k = 0;
    while (chars[which].size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check($sformatf("count_dut%0d", which), chars[which].size(), n);
  endtask

  task automatic cmp_word(string tag, int which, int off, ch_t exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (off + i < chars[which].size()) begin
        check($sformatf("%s_char[%0d]", tag, i), chars[which][off + i], exp[i]);
        check($sformatf("%s_last[%0d]", tag, i), lasts[which][off + i], (i == exp.size() - 1));
      end
    end
  endtask

  initial begin
    ch_t exp[$];
    ch_t exp2[$];
    logic [63:0] w0, w1;
    int k;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready",  a_in_ready,  1'b0);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_char",  a_out_char,  8'h00);
    check("rst_out_last",  a_out_last,  1'b0);
    check("rst_busy",      a_busy,      1'b0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rel_in_ready_a", a_in_ready, 1'b1);
    check("rel_in_ready_b", b_in_ready, 1'b1);
    check("rel_in_ready_c", c_in_ready, 1'b1);

    // DEADBEEF, full throughput
    clear(0);
    send(0, 64'hDEADBEEF);
    check("first_char_latency", a_out_valid, 1'b1);
    check("busy_in_word",       a_busy,      1'b1);
    check("in_ready_in_word",   a_in_ready,  1'b0);
    wait_chars(0, 12, 50);
    from_bits(96'h30_78_44_45_41_44_42_45_45_46_0D_0A, 12, exp);
    cmp_word("deadbeef", 0, 0, exp);
    if (cycs[0].size() == 12) check("deadbeef_consecutive", cycs[0][11] - cycs[0][0], 11);
    @(posedge clk); #1;
    check("deadbeef_busy_end",  a_busy,      1'b0);
    check("deadbeef_valid_end", a_out_valid, 1'b0);
    check("idle_out_char",      a_out_char,  8'h00);

    // 16-bit lowercase digits only
    clear(1);
    send(1, 64'h0A5F);
    wait_chars(1, 4, 50);
    from_bits(96'h30_61_35_66, 4, exp);
    cmp_word("w16_0a5f", 1, 0, exp);
    for (int r = 0; r < 3; r++) begin
      clear(1);
      w0 = 64'($urandom_range(0, 65535));
      model(16, 1'b1, 1'b0, 1'b0, w0, exp);
      send(1, w0);
      wait_chars(1, 4, 50);
      cmp_word("w16_rand", 1, 0, exp);
    end

    // 4-bit with prefix: F and then every nibble value
    clear(2);
    send(2, 64'hF);
    wait_chars(2, 3, 50);
    from_bits(96'h30_78_46, 3, exp);
    cmp_word("w4_f", 2, 0, exp);
    for (int v = 0; v < 16; v++) begin
      clear(2);
      model(4, 1'b0, 1'b1, 1'b0, 64'(v), exp);
      send(2, 64'(v));
      wait_chars(2, 3, 50);
      cmp_word($sformatf("w4_%0h", v), 2, 0, exp);
    end

    // Backpressure 1,0,0 pattern
    a_mode = 1;
    clear(0);
    model(32, 1'b0, 1'b1, 1'b1, 64'h12345678, exp);
    send(0, 64'h12345678);
    wait_chars(0, 12, 100);
    cmp_word("bp_12345678", 0, 0, exp);

    // Random words under random backpressure
    a_mode = 2;
    for (int r = 0; r < 4; r++) begin
      clear(0);
      w0 = 64'($urandom);
      model(32, 1'b0, 1'b1, 1'b1, w0, exp);
      send(0, w0);
      wait_chars(0, 12, 300);
      cmp_word("rand_bp", 0, 0, exp);
    end
    a_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // in_valid held high with in_data churning while busy
    clear(0);
    w0 = 64'($urandom);
    w1 = 64'($urandom);
    model(32, 1'b0, 1'b1, 1'b1, w0, exp);
    model(32, 1'b0, 1'b1, 1'b1, w1, exp2);
    @(posedge clk); #1;
    a_in_valid = 1'b1;
    a_in_data  = w0[31:0];
    k = 0;
    while (k < 200) begin
      @(posedge clk); #1;
      k++;
      if (chars[0].size() >= 12) break;
      a_in_data = $urandom;
    end
    check("hold_first_done", chars[0].size(), 12);
    check("hold_idle_ready", a_in_ready, 1'b1);
    a_in_data = w1[31:0];
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    wait_chars(0, 24, 60);
    cmp_word("hold_w0", 0, 0, exp);
    cmp_word("hold_w1", 0, 12, exp2);
    if (cycs[0].size() == 24) check("hold_gap", cycs[0][12] - cycs[0][11], 2);

    // Reset after three characters
    repeat (2) @(posedge clk);
    #1;
    clear(0);
    send(0, 64'hCAFEF00D);
    k = 0;
    while (chars[0].size() < 3 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("rst_mid_count", chars[0].size(), 3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid",    a_out_valid, 1'b0);
    check("rst_mid_char",     a_out_char,  8'h00);
    check("rst_mid_last",     a_out_last,  1'b0);
    check("rst_mid_busy",     a_busy,      1'b0);
    check("rst_mid_in_ready", a_in_ready,  1'b0);
    clear(0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst_mid_rel_ready", a_in_ready, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_no_leftover", chars[0].size(), 0);
    check("rst_mid_idle_busy",   a_busy, 1'b0);
    w0 = 64'($urandom);
    model(32, 1'b0, 1'b1, 1'b1, w0, exp);
    send(0, w0);
    wait_chars(0, 12, 50);
    cmp_word("after_rst", 0, 0, exp);

    repeat (3) @(posedge clk);
    #1;
    check("final_busy_a", a_busy, 1'b0);
    check("final_busy_b", b_busy, 1'b0);
    check("final_busy_c", c_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
